// File: rtl/fusion_pe_pkg.sv
// Shared types, precision codes and brick helpers for the fusion PE.
// The helpers work on fixed maximum widths (BRICK_W_MAX / OP_W_MAX) so that one
// package serves every legal parameterisation of fusion_pe; callers truncate.
package fusion_pe_pkg;

  localparam int unsigned BRICK_W_MAX = 16;
  localparam int unsigned OP_W_MAX    = 64;

  // Precision codes (brick count minus 1) for the default 2-bit brick.
  localparam int unsigned PREC_2B = 0;
  localparam int unsigned PREC_4B = 1;
  localparam int unsigned PREC_8B = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Brick number idx (bw bits wide) of an operand, zero-padded to BRICK_W_MAX.
  function automatic logic [BRICK_W_MAX-1:0] get_brick(
    input logic [OP_W_MAX-1:0] op,
    input int unsigned         idx,
    input int unsigned         bw
  );
    logic [OP_W_MAX-1:0] sh;
    sh = op >> (idx * bw);
    return BRICK_W_MAX'(sh) & ~({BRICK_W_MAX{1'b1}} << bw);
  endfunction

  // Extend a bw-bit brick by one or more bits, sign-extending only when sgn is set.
  function automatic logic [BRICK_W_MAX:0] ext_brick(
    input logic [BRICK_W_MAX-1:0] brick,
    input int unsigned            bw,
    input logic                   sgn
  );
    logic [BRICK_W_MAX:0] wide;
    logic [BRICK_W_MAX:0] mask;
    logic [BRICK_W_MAX:0] top;
    logic                 s;
    wide = (BRICK_W_MAX+1)'(brick);
    mask = ~({(BRICK_W_MAX+1){1'b1}} << bw);
    top  = wide >> (bw - 1);
    s    = sgn & top[0];
    return (wide & mask) | ({(BRICK_W_MAX+1){s}} & ~mask);
  endfunction

  // True when the low nbricks*bw bits of op are all zero.
  function automatic logic op_is_zero(
    input logic [OP_W_MAX-1:0] op,
    input int unsigned         nbricks,
    input int unsigned         bw
  );
    logic [OP_W_MAX-1:0] mask;
    mask = ~({OP_W_MAX{1'b1}} << (nbricks * bw));
    return (op & mask) == '0;
  endfunction

endpackage

// File: rtl/fusion_brick_mult.sv
// Combinational signed (BRICK_WIDTH+1) x (BRICK_WIDTH+1) brick multiplier.
// Ports: a, b  extended bricks (signed); p  full-width signed product.
module fusion_brick_mult #(
  parameter int unsigned BRICK_WIDTH = 2,
  localparam int unsigned PW = 2 * BRICK_WIDTH + 2
) (
  input  logic signed [BRICK_WIDTH:0] a,
  input  logic signed [BRICK_WIDTH:0] b,
  output logic signed [PW-1:0]        p
);

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] b_x;

  assign a_x = PW'(a);
  assign b_x = PW'(b);
  assign p   = a_x * b_x;

endmodule

// File: rtl/fusion_pe.sv
// Bit-composable processing element: fuses operands of runtime precision by
// walking brick pairs (j inner over operand 1, i outer over operand 0) through
// one small signed multiplier, shifting and accumulating each partial product.
// Ports: clk, reset (async, active-high); in_valid/in_ready handshake with
//   in_0/in_1 operands, prec_0/prec_1 brick-count-minus-1, signed_0/signed_1,
//   acc_clear; out_valid one-cycle completion pulse; out accumulator; busy.
// Build option FUSION_PE_ZERO_SKIP_EN: a pair with a zero operand (within its
//   precision) bypasses RUN and completes one cycle after acceptance.
module fusion_pe
  import fusion_pe_pkg::*;
#(
  parameter int unsigned BRICK_WIDTH = 2,
  parameter int unsigned MAX_PREC    = 8,
  parameter int unsigned ACC_WIDTH   = 32,
  localparam int unsigned NUM_BRICKS = MAX_PREC / BRICK_WIDTH,
  localparam int unsigned PREC_W     = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAX_PREC-1:0]  in_0,
  input  logic [MAX_PREC-1:0]  in_1,
  input  logic [PREC_W-1:0]    prec_0,
  input  logic [PREC_W-1:0]    prec_1,
  input  logic                 signed_0,
  input  logic                 signed_1,
  input  logic                 acc_clear,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out,
  output logic                 busy
);

  localparam int unsigned PW = 2 * BRICK_WIDTH + 2;

  if ((MAX_PREC % BRICK_WIDTH) != 0 || BRICK_WIDTH > BRICK_W_MAX || MAX_PREC > OP_W_MAX)
  begin : g_bad_cfg
    $error("fusion_pe: unsupported BRICK_WIDTH/MAX_PREC combination");
  end

  state_t                state_q, state_d;
  logic                  accept, last_pair, run, skip_c;
  logic [MAX_PREC-1:0]   a_q, b_q;
  logic [PREC_W-1:0]     pa_q, pb_q, i_q, j_q;
  logic                  sa_q, sb_q, clr_q;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic                  out_valid_q;

  logic signed [BRICK_WIDTH:0] a_ext, b_ext;
  logic signed [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0]        pp_ext, pp;
  int unsigned                 shamt;

  assign accept    = in_valid && in_ready;
  assign last_pair = (i_q == pa_q) && (j_q == pb_q);

`ifdef FUSION_PE_ZERO_SKIP_EN
  logic skip_q;
  // Judged on the incoming operands; they become the latched ones at this edge.
  assign skip_c = accept &&
                  (op_is_zero(OP_W_MAX'(in_0), 32'(prec_0) + 1, BRICK_WIDTH) ||
                   op_is_zero(OP_W_MAX'(in_1), 32'(prec_1) + 1, BRICK_WIDTH));
`else
  assign skip_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin : p_state
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: a new pair may start from IDLE or on the last RUN cycle.
  always_comb begin : p_next
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && !skip_c) state_d = RUN;
      RUN:  if (last_pair)         state_d = (accept && !skip_c) ? RUN : IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // State-decoded outputs and datapath enables.
  always_comb begin : p_out
    run      = 1'b0;
    busy     = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      RUN: begin
        run      = 1'b1;
        busy     = 1'b1;
        in_ready = last_pair;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Current brick pair; only the top brick of a signed operand is sign-extended.
  assign a_ext = (BRICK_WIDTH+1)'(ext_brick(get_brick(OP_W_MAX'(a_q), 32'(i_q), BRICK_WIDTH),
                                            BRICK_WIDTH, sa_q && (i_q == pa_q)));
  assign b_ext = (BRICK_WIDTH+1)'(ext_brick(get_brick(OP_W_MAX'(b_q), 32'(j_q), BRICK_WIDTH),
                                            BRICK_WIDTH, sb_q && (j_q == pb_q)));

  fusion_brick_mult #(.BRICK_WIDTH(BRICK_WIDTH)) u_mult (
    .a (a_ext),
    .b (b_ext),
    .p (prod)
  );

  assign pp_ext = ACC_WIDTH'(prod);
  assign shamt  = (32'(i_q) + 32'(j_q)) * BRICK_WIDTH;
  assign pp     = pp_ext << shamt;

  // Operand latch, brick counters, accumulator and completion pulse.
  always_ff @(posedge clk or posedge reset) begin : p_dp
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      pa_q        <= '0;
      pb_q        <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      clr_q       <= 1'b0;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef FUSION_PE_ZERO_SKIP_EN
      skip_q      <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_q   <= in_0;
        b_q   <= in_1;
        pa_q  <= prec_0;
        pb_q  <= prec_1;
        sa_q  <= signed_0;
        sb_q  <= signed_1;
        clr_q <= acc_clear;
        i_q   <= '0;
        j_q   <= '0;
      end else if (run) begin
        if (j_q == pb_q) begin
          j_q <= '0;
          i_q <= last_pair ? '0 : i_q + PREC_W'(1);
        end else begin
          j_q <= j_q + PREC_W'(1);
        end
      end

      if (run) begin
        acc_q <= (clr_q && (i_q == '0) && (j_q == '0)) ? pp : acc_q + pp;
      end
`ifdef FUSION_PE_ZERO_SKIP_EN
      // A skipped pair never coincides with RUN, and clr_q still holds its flag.
      else if (skip_q) begin
        acc_q <= clr_q ? '0 : acc_q;
      end
      skip_q      <= skip_c;
      out_valid_q <= (run && last_pair) || skip_q;
`else
      out_valid_q <= run && last_pair;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out       = acc_q;

endmodule
